// File: rtl/uart_pkg.sv
// Shared UART definitions: divisor defaults and oversample range.
// Used by the baud generator and its period counter.
package uart_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int FRAC_BITS_DEF = 8;
  localparam int OS_MIN        = 2;
  localparam int OS_MAX        = 64;

  // Fixed-point clocks per oversample period, int in upper bits, frac in low fb bits
  function automatic logic [63:0] default_div(
    input longint unsigned clk_frec,
    input longint unsigned baud,
    input longint unsigned os,
    input int              fb
  );
    return (clk_frec << fb) / (baud * os);
  endfunction

  function automatic bit os_legal(input int os);
    return (os >= OS_MIN) && (os <= OS_MAX);
  endfunction

endpackage

// File: rtl/frac_period_ctr.sv
// Fractional period counter: counts one oversample period of
// div_int (+1 on accumulator carry) clocks and flags its last clock.
module frac_period_ctr
  import uart_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [CNT_W-1:0]     div_int,
  input  logic [FRAC_BITS-1:0] div_frac,
  output logic                 term
);

  logic [CNT_W-1:0]     cnt;
  logic [FRAC_BITS-1:0] acc;
  logic [FRAC_BITS:0]   sum;
  logic [CNT_W-1:0]     base;
  logic [CNT_W:0]       last;

  // Period never shorter than two clocks
  assign base = (div_int < CNT_W'(2)) ? CNT_W'(2) : div_int;
  assign sum  = {1'b0, acc} + {1'b0, div_frac};
  assign last = {1'b0, base} + (CNT_W+1)'(sum[FRAC_BITS])
              - (CNT_W+1)'(1);
  assign term = en && ({1'b0, cnt} == last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (term) begin
      cnt <= '0;
      acc <= sum[FRAC_BITS-1:0];
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// UART baud generator with fractional divisor, oversample tick,
// bit tick, restart alignment and glitch-free divisor update.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int CLK_FREC   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 i_restart,
  input  logic                 i_div_wr,
  input  logic [CNT_W-1:0]     i_div_int,
  input  logic [FRAC_BITS-1:0] i_div_frac,
  output logic                 o_tick,
  output logic                 o_bit_tick,
  output logic [CNT_W-1:0]     o_div_int,
  output logic [FRAC_BITS-1:0] o_div_frac,
  output logic                 o_pending
);

  localparam logic [63:0] DEF_DIV = default_div(
    64'(CLK_FREC), 64'(BAUD_RATE), 64'(OVERSAMPLE), FRAC_BITS);
  localparam logic [CNT_W-1:0] DEF_INT =
    CNT_W'(DEF_DIV >> FRAC_BITS);
  localparam logic [FRAC_BITS-1:0] DEF_FRAC =
    FRAC_BITS'(DEF_DIV);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  if (!os_legal(OVERSAMPLE)) begin : g_os_chk
    $error("baud_gen_frac: OVERSAMPLE out of range");
  end

  logic                 term;
  logic                 tick;
  logic                 bit_tick;
  logic                 pending;
  logic                 swap;
  logic [OS_W-1:0]      os_cnt;
  logic [CNT_W-1:0]     act_int;
  logic [FRAC_BITS-1:0] act_frac;
  logic [CNT_W-1:0]     shd_int;
  logic [FRAC_BITS-1:0] shd_frac;

  frac_period_ctr #(
    .CNT_W     (CNT_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (i_enable),
    .clr      (i_restart),
    .div_int  (act_int),
    .div_frac (act_frac),
    .term     (term)
  );

  // Shadow may only take over at a period boundary or when idle
  assign swap = pending && (term || i_restart || !i_enable);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick     <= 1'b0;
      bit_tick <= 1'b0;
      os_cnt   <= '0;
      pending  <= 1'b0;
      act_int  <= DEF_INT;
      act_frac <= DEF_FRAC;
      shd_int  <= DEF_INT;
      shd_frac <= DEF_FRAC;
    end else begin
      tick     <= term && !i_restart;
      bit_tick <= term && !i_restart && (os_cnt == OS_LAST);
      if (i_restart) begin
        os_cnt <= '0;
      end else if (term) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      end
      if (i_restart && i_div_wr) begin
        act_int  <= i_div_int;
        act_frac <= i_div_frac;
        shd_int  <= i_div_int;
        shd_frac <= i_div_frac;
        pending  <= 1'b0;
      end else if (i_div_wr) begin
        if (swap) begin
          act_int  <= shd_int;
          act_frac <= shd_frac;
        end
        shd_int  <= i_div_int;
        shd_frac <= i_div_frac;
        pending  <= 1'b1;
      end else if (swap) begin
        act_int  <= shd_int;
        act_frac <= shd_frac;
        pending  <= 1'b0;
      end
    end
  end

  assign o_tick     = tick;
  assign o_bit_tick = bit_tick;
  assign o_div_int  = act_int;
  assign o_div_frac = act_frac;
  assign o_pending  = pending;

endmodule
